// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares one multi-cycle main memory between the I-cache
// and D-cache miss paths. Each grant performs a full block fill: BLOCK_WORDS
// consecutive word reads are issued, and the returning words are steered into
// the owning cache together with their word index.
//
// state  | meaning
// IDLE   | no fill in progress; sample pending misses and grant one
// FILL_I | issuing/receiving a block for the I-cache
// FILL_D | issuing/receiving a block for the D-cache
module cache_fill_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic [IDX_W-1:0]  fill_word,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2
  } state_t;

  localparam logic [IDX_W:0]    BW_CNT   = (IDX_W+1)'(BLOCK_WORDS);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(2*BLOCK_WORDS-1);

  state_t            state;
  logic [IDX_W:0]    issue_cnt;
  logic [IDX_W:0]    rx_cnt;
  logic [ADDR_W-1:0] base;
  logic              last_d;
  logic              i_done_q;
  logic              d_done_q;

  logic              filling;
  logic              rx_take;
  logic              i_req;
  logic              d_req;
  logic [ADDR_W-1:0] issue_ofs;
  logic [ADDR_W-1:0] rx_ofs;

  // Offsets are built from the low index bits only, so addresses stay inside
  // the block and can never carry into the tag bits.
  assign filling   = (state == FILL_I) || (state == FILL_D);
  assign rx_take   = filling && mem_data_valid && (rx_cnt < BW_CNT);
  assign issue_ofs = ADDR_W'({issue_cnt[IDX_W-1:0], 1'b0});
  assign rx_ofs    = ADDR_W'({rx_cnt[IDX_W-1:0], 1'b0});

  // A requester still holds its miss during its own done cycle; mask it so the
  // block that just finished is not fetched a second time.
  assign i_req = i_miss && !i_done_q;
  assign d_req = d_miss && !d_done_q;

  // Grant, counter and completion sequencing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      rx_cnt    <= '0;
      base      <= '0;
      last_d    <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req && (!i_req || !last_d)) begin
            state     <= FILL_D;
            base      <= d_miss_addr & ~OFS_MASK;
            last_d    <= 1'b1;
            issue_cnt <= '0;
            rx_cnt    <= '0;
          end else if (i_req) begin
            state     <= FILL_I;
            base      <= i_miss_addr & ~OFS_MASK;
            last_d    <= 1'b0;
            issue_cnt <= '0;
            rx_cnt    <= '0;
          end
        end
        FILL_I, FILL_D: begin
          if (issue_cnt < BW_CNT) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          if (rx_take) begin
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_cnt == BW_CNT - 1'b1) begin
              state <= IDLE;
              if (state == FILL_I) begin
                i_done_q <= 1'b1;
              end else begin
                d_done_q <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory request and fill steering, decoded from registered state so every
  // output is zero whenever no fill is active.
  always_comb begin
    mem_en    = filling && (issue_cnt < BW_CNT);
    mem_addr  = mem_en ? (base | issue_ofs) : '0;
    i_fill_we = rx_take && (state == FILL_I);
    d_fill_we = rx_take && (state == FILL_D);
    fill_data = rx_take ? mem_data_out : '0;
    fill_word = rx_take ? rx_cnt[IDX_W-1:0] : '0;
    fill_addr = rx_take ? (base | rx_ofs) : '0;
  end

  assign i_fill_done = i_done_q;
  assign d_fill_done = d_done_q;
  assign busy        = filling;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: a fixed-latency memory model plus a scoreboard
// of expected issue addresses and fill writes, checked as the DUT produces them.
module tb_cache_fill_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss;
  logic [15:0] i_miss_addr, d_miss_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data_out;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic [15:0] fill_addr;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy;

  cache_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .mem_data_valid(mem_data_valid), .mem_data_out(mem_data_out),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .fill_data(fill_data), .fill_word(fill_word), .fill_addr(fill_addr),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_d; logic [2:0] word; logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct { bit is_d; int cyc; } done_t;
  typedef struct { int cyc; logic [15:0] addr; } start_t;

  wr_t         exp_wr_q[$];
  logic [15:0] exp_iss_q[$];
  done_t       done_q[$];
  start_t      start_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int viol     = 0;
  int cyc      = 0;
  bit stray    = 1'b0;
  bit prev_busy = 1'b0;

  logic        pv[0:L];
  logic [15:0] pa[0:L];

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  always @(posedge clk) cyc++;

  // Memory model (latency L) and output scoreboard, run mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    logic [15:0] ea;
    for (int k = L; k > 0; k--) begin
      pv[k] = pv[k-1];
      pa[k] = pa[k-1];
    end
    pv[0] = mem_en;
    pa[0] = mem_addr;
    mem_data_valid = (pv[L] === 1'b1) || stray;
    mem_data_out   = (pv[L] === 1'b1) ? pat(pa[L]) : 16'h0000;
    #1;
    if (mem_en) begin
      n_assert++;
      if (exp_iss_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue: mem_addr=%h, required no issue", mem_addr);
      end else begin
        ea = exp_iss_q.pop_front();
        if (mem_addr !== ea) begin
          n_fail++;
          $display("FAIL issue_addr: got %h, required %h", mem_addr, ea);
        end
      end
    end
    if (i_fill_we || d_fill_we) begin
      n_assert++;
      if (exp_wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: i_we=%0b d_we=%0b word=%0d addr=%h, required no write",
                 i_fill_we, d_fill_we, fill_word, fill_addr);
      end else begin
        e = exp_wr_q.pop_front();
        if (d_fill_we !== e.is_d || i_fill_we !== !e.is_d || fill_word !== e.word ||
            fill_addr !== e.addr || fill_data !== e.data) begin
          n_fail++;
          $display("FAIL fill_write: got i=%0b d=%0b w=%0d a=%h data=%h, required d=%0b w=%0d a=%h data=%h",
                   i_fill_we, d_fill_we, fill_word, fill_addr, fill_data, e.is_d, e.word, e.addr, e.data);
        end
      end
    end
    if (i_fill_done) done_q.push_back('{1'b0, cyc});
    if (d_fill_done) done_q.push_back('{1'b1, cyc});
    if (busy && !prev_busy) start_q.push_back('{cyc, mem_addr});
    if (i_fill_we && d_fill_we) viol++;
    if (i_fill_done && d_fill_done) viol++;
    if ((i_fill_we || d_fill_we) && !busy) viol++;
    prev_busy = busy;
  end

  task automatic push_fill(input bit is_d, input logic [15:0] base, input int n_wr);
    for (int k = 0; k < 8; k++) exp_iss_q.push_back(base + 16'(2*k));
    for (int k = 0; k < n_wr; k++) begin
      wr_t e;
      e.is_d = is_d;
      e.word = 3'(k);
      e.addr = base + 16'(2*k);
      e.data = pat(e.addr);
      exp_wr_q.push_back(e);
    end
  endtask

  task automatic wait_done(input bit is_d, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk); #2;
      seen = is_d ? d_fill_done : i_fill_done;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_assert++;
    if ({mem_en, mem_addr, busy, i_fill_we, d_fill_we, i_fill_done, d_fill_done} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%0b addr=%h busy=%0b we=%0b%0b done=%0b%0b, required all 0",
               mem_en, mem_addr, busy, i_fill_we, d_fill_we, i_fill_done, d_fill_done);
    end
    n_assert++;
    if ({fill_word, fill_addr, fill_data} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_fill_bus: word=%0d addr=%h data=%h, required 0", fill_word, fill_addr, fill_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_i_only;
    bit seen;
    start_t s;
    done_t d;
    push_fill(1'b0, 16'h1230, 8);
    i_miss_addr = 16'h1236;
    i_miss = 1'b1;
    wait_done(1'b0, seen);
    i_miss = 1'b0;
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL i_only_done: got no i_fill_done, required pulse"); end
    @(negedge clk); #3;
    n_assert++;
    if (exp_wr_q.size() != 0 || exp_iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL i_only_drain: got %0d writes %0d issues left, required 0", exp_wr_q.size(), exp_iss_q.size());
    end
    n_assert++;
    if (start_q.size() != 1 || done_q.size() != 1) begin
      n_fail++;
      $display("FAIL i_only_events: got %0d starts %0d dones, required 1 1", start_q.size(), done_q.size());
    end else begin
      s = start_q.pop_front();
      d = done_q.pop_front();
      n_assert++;
      if (s.addr !== 16'h1230 || d.is_d || (d.cyc - s.cyc) != 12) begin
        n_fail++;
        $display("FAIL i_only_timing: got base=%h is_d=%0b done-start=%0d, required 1230 0 12",
                 s.addr, d.is_d, d.cyc - s.cyc);
      end
    end
    start_q.delete(); done_q.delete();
  endtask

  task automatic test_tie_after_reset;
    bit seen;
    start_t s0, s1;
    push_fill(1'b1, 16'h8000, 8);
    push_fill(1'b0, 16'h0040, 8);
    i_miss_addr = 16'h0040; d_miss_addr = 16'h8008;
    i_miss = 1'b1; d_miss = 1'b1;
    wait_done(1'b1, seen);
    d_miss = 1'b0;
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL tie_d_done: got no d_fill_done, required pulse"); end
    wait_done(1'b0, seen);
    i_miss = 1'b0;
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL tie_i_done: got no i_fill_done, required pulse"); end
    @(negedge clk); #3;
    n_assert++;
    if (start_q.size() != 2 || done_q.size() != 2) begin
      n_fail++;
      $display("FAIL tie_events: got %0d starts %0d dones, required 2 2", start_q.size(), done_q.size());
    end else begin
      s0 = start_q[0]; s1 = start_q[1];
      n_assert++;
      if (s0.addr !== 16'h8000 || s1.addr !== 16'h0040 || !done_q[0].is_d || s1.cyc != done_q[0].cyc + 1) begin
        n_fail++;
        $display("FAIL tie_order: got bases %h,%h first_is_d=%0b gap=%0d, required 8000,0040 1 1",
                 s0.addr, s1.addr, done_q[0].is_d, s1.cyc - done_q[0].cyc);
      end
    end
    n_assert++;
    if (exp_wr_q.size() != 0 || exp_iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL tie_drain: got %0d writes %0d issues left, required 0", exp_wr_q.size(), exp_iss_q.size());
    end
    start_q.delete(); done_q.delete();
  endtask

  task automatic test_round_robin;
    bit seen;
    push_fill(1'b1, 16'h3000, 8);
    d_miss_addr = 16'h3002; d_miss = 1'b1;
    wait_done(1'b1, seen);
    d_miss = 1'b0;
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL rr_pre_done: got no d_fill_done, required pulse"); end
    @(posedge clk); #2;
    // Tie after a D fill: I must win.
    push_fill(1'b0, 16'h0100, 8);
    i_miss_addr = 16'h010A; d_miss_addr = 16'h3100;
    i_miss = 1'b1; d_miss = 1'b1;
    wait_done(1'b0, seen);
    i_miss = 1'b0; d_miss = 1'b0;
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL rr_tie1: got no i_fill_done, required I granted"); end
    @(posedge clk); #2;
    // Tie after an I fill: D must win.
    push_fill(1'b1, 16'h3100, 8);
    i_miss = 1'b1; d_miss = 1'b1;
    wait_done(1'b1, seen);
    i_miss = 1'b0; d_miss = 1'b0;
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL rr_tie2: got no d_fill_done, required D granted"); end
    @(negedge clk); #3;
    n_assert++;
    if (exp_wr_q.size() != 0 || exp_iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_drain: got %0d writes %0d issues left, required 0", exp_wr_q.size(), exp_iss_q.size());
    end
    start_q.delete(); done_q.delete();
  endtask

  task automatic test_drop_mid_fill;
    bit seen;
    push_fill(1'b1, 16'h2000, 8);
    d_miss_addr = 16'h2000; d_miss = 1'b1;
    // Grant edge ends this cycle; word 2 is received 7 cycles later.
    repeat (7) @(posedge clk);
    #2;
    d_miss_addr = 16'h4444; d_miss = 1'b0;
    wait_done(1'b1, seen);
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL drop_done: got no d_fill_done, required pulse"); end
    @(negedge clk); #3;
    n_assert++;
    if (exp_wr_q.size() != 0 || exp_iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL drop_drain: got %0d writes %0d issues left, required 0", exp_wr_q.size(), exp_iss_q.size());
    end
    start_q.delete(); done_q.delete();
  endtask

  task automatic test_wrap_and_stray;
    bit seen;
    push_fill(1'b1, 16'hFFF0, 8);
    d_miss_addr = 16'hFFFE; d_miss = 1'b1;
    wait_done(1'b1, seen);
    d_miss = 1'b0;
    n_assert++;
    if (!seen) begin n_fail++; $display("FAIL wrap_done: got no d_fill_done, required pulse"); end
    @(negedge clk); #3;
    n_assert++;
    if (exp_wr_q.size() != 0 || exp_iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_drain: got %0d writes %0d issues left, required 0", exp_wr_q.size(), exp_iss_q.size());
    end
    stray = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #2;
      n_assert++;
      if (i_fill_we || d_fill_we || busy) begin
        n_fail++;
        $display("FAIL stray_valid: got i_we=%0b d_we=%0b busy=%0b, required 0", i_fill_we, d_fill_we, busy);
      end
    end
    stray = 1'b0;
    @(posedge clk); #2;
    start_q.delete(); done_q.delete();
  endtask

  task automatic test_reset_mid_fill;
    push_fill(1'b1, 16'h5000, 4);
    d_miss_addr = 16'h5000; d_miss = 1'b1;
    // Word 3 is received in the 8th cycle after this one.
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0; d_miss = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    n_assert++;
    if ({mem_en, mem_addr, busy, i_fill_we, d_fill_we, i_fill_done, d_fill_done} !== 21'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: en=%0b addr=%h busy=%0b we=%0b%0b done=%0b%0b, required all 0",
               mem_en, mem_addr, busy, i_fill_we, d_fill_we, i_fill_done, d_fill_done);
    end
    repeat (8) @(posedge clk);
    #2;
    n_assert++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_done: got %0d done pulses, required 0", done_q.size());
    end
    n_assert++;
    if (exp_wr_q.size() != 0 || exp_iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_drain: got %0d writes %0d issues left, required 0", exp_wr_q.size(), exp_iss_q.size());
    end
    start_q.delete(); done_q.delete();
  endtask

  initial begin
    for (int k = 0; k <= L; k++) begin pv[k] = 1'b0; pa[k] = 16'h0; end
    rst_n = 1'b0;
    i_miss = 1'b0; d_miss = 1'b0;
    i_miss_addr = 16'h0; d_miss_addr = 16'h0;
    mem_data_valid = 1'b0; mem_data_out = 16'h0;
    test_reset;
    test_tie_after_reset;
    test_i_only;
    test_round_robin;
    test_drop_mid_fill;
    test_wrap_and_stray;
    test_reset_mid_fill;
    n_assert++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL exclusivity: got %0d cycles with overlapping/idle enables, required 0", viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
